// File: rtl/operand_aligner.sv
// Float add/sub front end: unpacks two operands, orders them by magnitude and
// aligns the smaller mantissa to the larger exponent. Define ALIGN_BARREL_EN for a single-cycle barrel shift.
module operand_aligner #(
   parameter int EXP_SIZE    = 8,
   parameter int MANTIS_SIZE = 23,
   localparam int W  = 1 + EXP_SIZE + MANTIS_SIZE,
   localparam int MW = MANTIS_SIZE + 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        a_in,
   input  logic [W-1:0]        b_in,
   input  logic                operator_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                sign_out,
   output logic                operator_out,
   output logic [EXP_SIZE-1:0] exp_out,
   output logic [MW-1:0]       mantis_big_out,
   output logic [MW-1:0]       mantis_small_out,
   output logic                loss
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t state_q, state_d;
   logic                sign_q, sign_d, op_q, op_d, loss_q, loss_d;
   logic [EXP_SIZE-1:0] exp_q, exp_d;
   logic [MW-1:0]       big_q, big_d, small_q, small_d;
`ifndef ALIGN_BARREL_EN
   localparam int CW = $clog2(MW);
   logic [CW-1:0]       count_q, count_d;
`endif

   logic                   sa, sb, a_big, sat;
   logic [EXP_SIZE-1:0]    ea, eb, e_big, e_small, ee_big, ee_small, diff;
   logic [MANTIS_SIZE-1:0] fa, fb, f_big, f_small;
   logic [MW-1:0]          m_big, m_small;

   always_comb begin
      sa = a_in[W-1];
      sb = b_in[W-1];
      ea = a_in[W-2 -: EXP_SIZE];
      eb = b_in[W-2 -: EXP_SIZE];
      fa = a_in[MANTIS_SIZE-1:0];
      fb = b_in[MANTIS_SIZE-1:0];
      a_big   = {ea, fa} >= {eb, fb};
      e_big   = a_big ? ea : eb;
      e_small = a_big ? eb : ea;
      f_big   = a_big ? fa : fb;
      f_small = a_big ? fb : fa;
      m_big   = {1'b0, |e_big,   f_big,   1'b0};
      m_small = {1'b0, |e_small, f_small, 1'b0};
      // Denormals share the scale of exponent 1.
      ee_big   = (e_big   == '0) ? EXP_SIZE'(1) : e_big;
      ee_small = (e_small == '0) ? EXP_SIZE'(1) : e_small;
      diff = ee_big - ee_small;
      sat  = 32'(diff) > 32'(MW - 1);
   end

`ifdef ALIGN_BARREL_EN
   logic [MW-1:0] lost_mask;
   assign lost_mask = ~({MW{1'b1}} << diff);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         op_q    <= 1'b0;
         loss_q  <= 1'b0;
         exp_q   <= '0;
         big_q   <= '0;
         small_q <= '0;
`ifndef ALIGN_BARREL_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         op_q    <= op_d;
         loss_q  <= loss_d;
         exp_q   <= exp_d;
         big_q   <= big_d;
         small_q <= small_d;
`ifndef ALIGN_BARREL_EN
         count_q <= count_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      op_d    = op_q;
      loss_d  = loss_q;
      exp_d   = exp_q;
      big_d   = big_q;
      small_d = small_q;
`ifndef ALIGN_BARREL_EN
      count_d = count_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            sign_d  = a_big ? sa : sb;
            op_d    = operator_in ^ sa ^ sb;
            exp_d   = e_big;
            big_d   = m_big;
            loss_d  = 1'b0;
            state_d = DONE;
            if (sat) begin
               small_d = '0;
               loss_d  = |m_small;
            end else begin
`ifdef ALIGN_BARREL_EN
               small_d = m_small >> diff;
               loss_d  = |(m_small & lost_mask);
`else
               small_d = m_small;
               count_d = diff[CW-1:0];
               if (diff != '0) state_d = SHIFT;
`endif
            end
         end
`ifndef ALIGN_BARREL_EN
         SHIFT: begin
            small_d = small_q >> 1;
            loss_d  = loss_q | small_q[0];
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = DONE;
         end
`endif
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready         = (state_q == IDLE);
      out_valid        = (state_q == DONE);
      sign_out         = sign_q;
      operator_out     = op_q;
      exp_out          = exp_q;
      mantis_big_out   = big_q;
      mantis_small_out = small_q;
      loss             = loss_q;
   end

endmodule

// File: tb/tb_operand_aligner.sv
// Self-checking bench for operand_aligner: directed cases, randomized pairs
// against a magnitude/arithmetic reference model, backpressure and mid-shift reset.
module tb_operand_aligner;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, operator_in = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic        out_valid, out_ready = 1'b0;
   logic        sign_out, operator_out, loss;
   logic [7:0]  exp_out;
   logic [25:0] mantis_big_out, mantis_small_out;

   int checks = 0, passed = 0;

   operand_aligner dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .operator_in(operator_in),
      .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
      .operator_out(operator_out), .exp_out(exp_out),
      .mantis_big_out(mantis_big_out), .mantis_small_out(mantis_small_out),
      .loss(loss)
   );

   always #5 clk = ~clk;

   function automatic logic [62:0] got_vec();
      return {sign_out, operator_out, exp_out, mantis_big_out, mantis_small_out, loss};
   endfunction

   // Reference: {sign, op, exp, big, small, loss} plus expected latency.
   function automatic logic [62:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic op, output int lat);
      logic [31:0] big, sml;
      int eb, es, d;
      longint mb, ms, s;
      logic l;
      big = (a[30:0] >= b[30:0]) ? a : b;
      sml = (a[30:0] >= b[30:0]) ? b : a;
      eb = int'(big[30:23]);
      es = int'(sml[30:23]);
      d  = ((eb == 0) ? 1 : eb) - ((es == 0) ? 1 : es);
      mb = ((eb != 0) ? 64'd16777216 : 64'd0) + longint'(big[22:0]) * 2;
      ms = ((es != 0) ? 64'd16777216 : 64'd0) + longint'(sml[22:0]) * 2;
      if (d > 25) begin
         s = 0; l = (ms != 0); lat = 1;
      end else begin
         s = ms / (64'd1 << d);
         l = (ms % (64'd1 << d)) != 0;
         lat = d + 1;
      end
`ifdef ALIGN_BARREL_EN
      lat = 1;
`endif
      return {big[31], op ^ a[31] ^ b[31], big[30:23], mb[25:0], s[25:0], l};
   endfunction

   // Drives one pair and waits (bounded) for out_valid; no checking here.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output int lat);
      @(negedge clk);
      a_in = a; b_in = b; operator_in = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({in_ready, out_valid, got_vec()} !== {1'b1, 1'b0, 63'd0})
         $display("FAIL reset: got rdy=%b vld=%b data=%h, want rdy=1 vld=0 data=0",
                  in_ready, out_valid, got_vec());
      else passed++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] ta[5] = '{32'h40400000, 32'h3F800000, 32'h40800000, 32'h4F800000, 32'h00000003};
      logic [31:0] tb[5] = '{32'h3F800000, 32'h40400000, 32'h3F800001, 32'h3F800000, 32'h00800001};
      logic        to[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [62:0] exp_v;
      int lat, exp_lat;
      for (int i = 0; i < 5; i++) begin
         exp_v = model(ta[i], tb[i], to[i], exp_lat);
         drive(ta[i], tb[i], to[i], lat);
         checks++;
         if (got_vec() !== exp_v)
            $display("FAIL directed[%0d] data: got %h want %h", i, got_vec(), exp_v);
         else passed++;
         checks++;
         if (lat !== exp_lat)
            $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, exp_lat);
         else passed++;
         release_out();
      end
      // Spot-check the spec's literal numbers for the first case too.
      drive(32'h40400000, 32'h3F800000, 1'b0, lat);
      checks++;
      if ({exp_out, mantis_big_out, mantis_small_out, loss} !== {8'h80, 26'h1800000, 26'h0800000, 1'b0})
         $display("FAIL literal_case: got exp=%h big=%h small=%h loss=%b want 80/1800000/0800000/0",
                  exp_out, mantis_big_out, mantis_small_out, loss);
      else passed++;
      release_out();
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [7:0]  ea, eb;
      logic        op;
      logic [62:0] exp_v;
      int lat, exp_lat;
      for (int i = 0; i < 40; i++) begin
         ea = 8'($urandom_range(0, 254));
         eb = (ea > 30) ? ea - 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 3));
         a = {1'($urandom), ea, 23'($urandom)};
         b = {1'($urandom), eb, 23'($urandom)};
         if (i % 7 == 3) b = {~a[31], a[30:0]};
         if ($urandom_range(0, 1) == 1) {a, b} = {b, a};
         op = 1'($urandom);
         exp_v = model(a, b, op, exp_lat);
         drive(a, b, op, lat);
         checks++;
         if (got_vec() !== exp_v || lat !== exp_lat)
            $display("FAIL random[%0d] a=%h b=%h: got %h lat %0d want %h lat %0d",
                     i, a, b, got_vec(), lat, exp_v, exp_lat);
         else passed++;
         release_out();
      end
   endtask

   task automatic test_backpressure();
      logic [62:0] exp_v;
      int lat, exp_lat;
      exp_v = model(32'h40800000, 32'h3F800001, 1'b1, exp_lat);
      drive(32'h40800000, 32'h3F800001, 1'b1, lat);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({out_valid, in_ready, got_vec()} !== {1'b1, 1'b0, exp_v})
            $display("FAIL hold[%0d]: got vld=%b rdy=%b %h want vld=1 rdy=0 %h",
                     c, out_valid, in_ready, got_vec(), exp_v);
         else passed++;
         @(posedge clk); #1;
      end
      release_out();
      checks++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      else passed++;
   endtask

   task automatic test_reset_mid_shift();
      logic [62:0] exp_v;
      int lat, exp_lat;
      @(negedge clk);
      a_in = 32'h44800000; b_in = 32'h3F800000; operator_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, got_vec()} !== {1'b1, 1'b0, 63'd0})
         $display("FAIL reset_mid: got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0",
                  in_ready, out_valid, got_vec());
      else passed++;
      @(negedge clk); rst = 1'b0;
      exp_v = model(32'hC1200000, 32'h40A00000, 1'b0, exp_lat);
      drive(32'hC1200000, 32'h40A00000, 1'b0, lat);
      checks++;
      if (got_vec() !== exp_v || lat !== exp_lat)
         $display("FAIL after_reset: got %h lat %0d want %h lat %0d", got_vec(), lat, exp_v, exp_lat);
      else passed++;
      release_out();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/operand_aligner.md
Name: operand_aligner

Overview:
- Front end of the float add/sub datapath; it is the producer side of the standardizer interface.
- Unpacks two packed floats and orders them by magnitude.
- Right-shifts the smaller mantissa serially, one bit per cycle, until both share the larger exponent.
- Delivers the shared exponent, both extended mantissas (MANTIS_SIZE+3 bits), the effective operator and the sticky loss bit that the standardizer's round stage consumes.

Parameters:
EXP_SIZE, 8 (`EXP_SIZE from configuration.v), exponent field width
MANTIS_SIZE, 23 (`MANTIS_SIZE from configuration.v), stored fraction width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  aligner can accept a pair
a_in  input  1+EXP_SIZE+MANTIS_SIZE  operand A: {sign, exp, fraction}
b_in  input  1+EXP_SIZE+MANTIS_SIZE  operand B: {sign, exp, fraction}
operator_in  input  1  0 = add, 1 = subtract
out_valid  output  1  aligned result valid
out_ready  input  1  consumer accepts result
sign_out  output  1  sign of the larger-magnitude operand
operator_out  output  1  effective operation, operator_in ^ sign_a ^ sign_b
exp_out  output  EXP_SIZE  common (larger) exponent
mantis_big_out  output  MANTIS_SIZE+3  larger operand mantissa
mantis_small_out  output  MANTIS_SIZE+3  aligned smaller operand mantissa
loss  output  1  OR of every bit shifted out below the guard position

Behaviour:
- Extended mantissa layout: [M+2] carry = 0, [M+1] hidden = (exp != 0), [M:1] fraction, [0] guard = 0, where M = MANTIS_SIZE.
- Exponent 0 is treated as 1 for the difference calculation; exp_out reports the raw larger exponent.
- Ordering: A is "big" if {expA, fracA} >= {expB, fracB}, else the operands swap. Equal magnitudes leave A as big.
- diff = exp_big - exp_small (unsigned).
- Saturation: if diff > M+2, the small mantissa is forced to 0 and loss = OR of all its bits; no shift cycles occur.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready = 1. On in_valid, capture the operands and sort them, load count = diff, clear loss. Next state is DONE if diff == 0 or saturated, else SHIFT.
  - SHIFT: each edge shifts the small mantissa right by 1, does loss |= old bit[0], and decrements count. Enter DONE on the edge where count reaches 0.
  - DONE: out_valid = 1 and all outputs hold stable while out_ready = 0. On out_ready, go to IDLE.
- in_ready = 0 in SHIFT and DONE. There is no same-cycle re-accept on the DONE-to-IDLE edge.
- Latency from accept edge to out_valid high: d+1 cycles, where d = diff (d = 0 when saturated).
- Reset, including mid-operation: state IDLE, in_ready = 1, out_valid = 0, every data output 0, loss 0, count 0. Any in-flight pair is dropped.
- Outputs are registered; none depends combinationally on in_* inputs.

Optional Feature:
- Macro: ALIGN_BARREL_EN.
- Defined: SHIFT state is removed; the full shift and sticky OR are done combinationally at capture. Latency is fixed at 1 cycle (accept, then DONE), and results are bit-identical to the serial path.
- Undefined: serial shifter as specified above.

Test Plan:
- a=0x40400000, b=0x3F800000, op=0 -> exp_out=0x80, big=0x1800000, small=0x0800000, loss=0, operator_out=0, out_valid 2 cycles after accept.
- a=0x3F800000, b=0x40400000, op=1 -> swap: same mantissas as above, sign_out=0, operator_out=1.
- a=0x40800000, b=0x3F800001 (diff 2) -> small=0x0400000, loss=1.
- a=0x4F800000, b=0x3F800000 (diff 32, saturated) -> small=0, loss=1, out_valid 1 cycle after accept.
- out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 the next cycle.
- rst asserted during SHIFT (diff 10, after 3 shifts) -> outputs zero immediately. After release, a new pair processes correctly.
